mcpu_mem_arbiter: RTL and testbench

Arbiter sharing the single-port 256x16 MCPU RAM between three requesters: program loader (replaces backdoor memory init), instruction fetch, and data load/store.
- Grants at most one access per cycle and drives the RAM port.
- Returns read data with a per-requester valid strobe.
- Sits between the MCPU control/datapath and the RAM instance.

---
 rtl/mcpu_pkg.sv | 21 ++
 rtl/mcpu_rr_pick.sv | 35 +++
 rtl/mcpu_mem_arbiter.sv | 104 ++++++++++
 tb/tb_mcpu_mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared MCPU constants: RAM geometry, memory requester indices and arbiter state encoding.
package mcpu_pkg;

   localparam int unsigned WORD_SIZE = 16;
   localparam int unsigned ADDR_W    = 8;
   localparam int unsigned RAM_SIZE  = 256;

   localparam int unsigned REQ_LOAD  = 0;
   localparam int unsigned REQ_FETCH = 1;
   localparam int unsigned REQ_DATA  = 2;

   localparam logic [0:0] NORMAL = 1'b0;
   localparam logic [0:0] STARVE = 1'b1;

   typedef struct packed {
      logic                 we;
      logic [ADDR_W-1:0]    addr;
      logic [WORD_SIZE-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mcpu_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to 0.
module mcpu_rr_pick #(
   parameter int unsigned N = 2,
   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt_c,
   output logic [PW-1:0] nxt_ptr_c
);

   logic found_c;

   // First pass honours the pointer, second pass covers the wrap-around.
   always_comb begin
      gnt_c     = '0;
      nxt_ptr_c = ptr;
      found_c   = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found_c && req[i] && (PW'(i) >= ptr)) begin
            gnt_c[i]  = 1'b1;
            nxt_ptr_c = (i == N - 1) ? '0 : PW'(i + 1);
            found_c   = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (!found_c && req[i]) begin
            gnt_c[i]  = 1'b1;
            nxt_ptr_c = (i == N - 1) ? '0 : PW'(i + 1);
            found_c   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mcpu_mem_arbiter.sv
// Shares the single-port MCPU RAM between loader (fixed priority, starvation-limited),
// instruction fetch and data load/store (round-robin between the latter two).
module mcpu_mem_arbiter
   import mcpu_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 3,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           we,
   input  logic [NUM_REQ*ADDR_W-1:0]    addr,
   input  logic [NUM_REQ*WORD_SIZE-1:0] wdata,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           rvalid,
   output logic [WORD_SIZE-1:0]         rdata,
   output logic                         mem_en,
   output logic                         mem_we,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [WORD_SIZE-1:0]         mem_wdata,
   input  logic [WORD_SIZE-1:0]         mem_rdata
);

   localparam int unsigned RR_N  = NUM_REQ - 1;
   localparam int unsigned PTR_W = (RR_N > 1) ? $clog2(RR_N) : 1;
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [0:0]         state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;      // relative to REQ_FETCH: 0 means requester 1
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
   logic [RR_N-1:0]    rr_gnt_c;
   logic [PTR_W-1:0]   rr_nxt_c;
   logic               others_c;
   mem_req_t           sel_c;

   mcpu_rr_pick #(.N(RR_N)) u_rr_pick (
      .req       (req[NUM_REQ-1:REQ_FETCH]),
      .ptr       (ptr_q),
      .gnt_c     (rr_gnt_c),
      .nxt_ptr_c (rr_nxt_c)
   );

   assign others_c = |req[NUM_REQ-1:REQ_FETCH];

   // Arbitration and next-state; grant is forced low while reset is asserted.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt     = '0;
      if (state_q == STARVE) begin
         gnt     = {rr_gnt_c, 1'b0};
         cnt_d   = '0;
         state_d = NORMAL;
         if (|rr_gnt_c) ptr_d = rr_nxt_c;
      end else if (req[REQ_LOAD]) begin
         gnt[REQ_LOAD] = 1'b1;
         cnt_d = others_c ? CNT_W'(cnt_q + 1'b1) : '0;
         if (others_c && (cnt_d == CNT_W'(STARVE_LIMIT))) state_d = STARVE;
      end else begin
         gnt   = {rr_gnt_c, 1'b0};
         cnt_d = '0;
         if (|rr_gnt_c) ptr_d = rr_nxt_c;
      end
      if (!reset) gnt = '0;
   end

   // RAM port mux from the granted requester; zero when idle.
   always_comb begin
      sel_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_c.we    = we[i];
            sel_c.addr  = addr[i*ADDR_W +: ADDR_W];
            sel_c.wdata = wdata[i*WORD_SIZE +: WORD_SIZE];
         end
      end
      rvalid_d = gnt & ~we;
   end

   assign mem_en    = |gnt;
   assign mem_we    = sel_c.we;
   assign mem_addr  = sel_c.addr;
   assign mem_wdata = sel_c.wdata;
   assign rvalid    = rvalid_q;
   assign rdata     = (|rvalid_q) ? mem_rdata : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= NORMAL;
         ptr_q    <= '0;
         cnt_q    <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
      end
   end

endmodule

// File: tb/tb_mcpu_mem_arbiter.sv
// Self-checking bench for mcpu_mem_arbiter with a behavioural 256x16 registered-read RAM.
module tb_mcpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req, we, gnt, rvalid;
   logic [23:0] addr;
   logic [47:0] wdata;
   logic [15:0] rdata, mem_wdata, mem_rdata;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;

   always #5 clk = ~clk;

   mcpu_mem_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   logic [15:0] ram [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct packed {
      logic [2:0]  req;
      logic [2:0]  we;
      logic [7:0]  a0, a1, a2;
      logic [15:0] d0, d2;
      logic [2:0]  gnt;
   } vec_t;

   typedef struct packed {
      logic [2:0]  rv;
      logic [15:0] data;
   } rd_t;

   rd_t         sb[$];
   logic [15:0] shadow [256];
   vec_t        tbl [15];
   int          checks = 0;
   int          errors = 0;

   function automatic vec_t mk(logic [2:0] r, logic [2:0] w, logic [7:0] a0, logic [7:0] a1,
                               logic [7:0] a2, logic [15:0] d0, logic [15:0] d2, logic [2:0] g);
      vec_t v;
      v.req = r; v.we = w; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.d0 = d0; v.d2 = d2; v.gnt = g;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pops the read expected from last cycle's grant, or requires no rvalid.
   task automatic check_rv();
      rd_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rvalid", 32'(rvalid), 32'(e.rv));
         chk("rdata", 32'(rdata), 32'(e.data));
      end else begin
         chk("rvalid_idle", 32'(rvalid), 32'd0);
      end
   endtask

   task automatic drive(input vec_t v);
      logic        ew;
      logic [7:0]  ea;
      logic [15:0] ed;
      @(negedge clk);
      check_rv();
      req   = v.req;
      we    = v.we;
      addr  = {v.a2, v.a1, v.a0};
      wdata = {v.d2, 16'h0000, v.d0};
      #1;
      case (v.gnt)
         3'b001:  begin ew = v.we[0]; ea = v.a0; ed = v.d0;    end
         3'b010:  begin ew = v.we[1]; ea = v.a1; ed = 16'h0;   end
         3'b100:  begin ew = v.we[2]; ea = v.a2; ed = v.d2;    end
         default: begin ew = 1'b0;    ea = 8'h0; ed = 16'h0;   end
      endcase
      chk("gnt", 32'(gnt), 32'(v.gnt));
      chk("mem_en", 32'(mem_en), 32'(|v.gnt));
      chk("mem_we", 32'(mem_we), 32'(ew));
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_wdata", 32'(mem_wdata), 32'(ed));
      if (v.gnt != 3'b000) begin
         if (ew) shadow[ea] = ed;
         else    sb.push_back('{v.gnt, shadow[ea]});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lk, fj, run;
      vec_t v;

      for (int i = 0; i < 256; i++) begin
         ram[i]    <= 16'(i * 7 + 3);
         shadow[i]  = 16'(i * 7 + 3);
      end

      // rows: req, we, a0, a1, a2, d0, d2, expected gnt
      tbl[0]  = mk(3'b111, 3'b001, 8'd0,  8'd0,   8'd1,   16'h1044, 16'h0000, 3'b001);
      tbl[1]  = mk(3'b110, 3'b000, 8'd0,  8'd0,   8'd1,   16'h0000, 16'h0000, 3'b010);
      tbl[2]  = mk(3'b110, 3'b000, 8'd0,  8'd2,   8'd1,   16'h0000, 16'h0000, 3'b100);
      tbl[3]  = mk(3'b110, 3'b000, 8'd0,  8'd3,   8'd4,   16'h0000, 16'h0000, 3'b010);
      tbl[4]  = mk(3'b110, 3'b000, 8'd0,  8'd5,   8'd4,   16'h0000, 16'h0000, 3'b100);
      tbl[5]  = mk(3'b010, 3'b000, 8'd0,  8'd0,   8'd0,   16'h0000, 16'h0000, 3'b010);
      tbl[6]  = mk(3'b000, 3'b000, 8'd0,  8'd0,   8'd0,   16'h0000, 16'h0000, 3'b000);
      tbl[7]  = mk(3'b100, 3'b100, 8'd0,  8'd0,   8'd100, 16'h0000, 16'h0044, 3'b100);
      tbl[8]  = mk(3'b100, 3'b000, 8'd0,  8'd0,   8'd100, 16'h0000, 16'h0000, 3'b100);
      tbl[9]  = mk(3'b110, 3'b100, 8'd0,  8'd100, 8'd50,  16'h0000, 16'hBEEF, 3'b010);
      tbl[10] = mk(3'b110, 3'b100, 8'd0,  8'd51,  8'd50,  16'h0000, 16'hBEEF, 3'b100);
      tbl[11] = mk(3'b100, 3'b000, 8'd0,  8'd0,   8'd50,  16'h0000, 16'h0000, 3'b100);
      tbl[12] = mk(3'b011, 3'b000, 8'd50, 8'd100, 8'd0,   16'h0000, 16'h0000, 3'b001);
      tbl[13] = mk(3'b010, 3'b000, 8'd0,  8'd50,  8'd0,   16'h0000, 16'h0000, 3'b010);
      tbl[14] = mk(3'b000, 3'b000, 8'd0,  8'd0,   8'd0,   16'h0000, 16'h0000, 3'b000);

      // Reset held with every requester asking.
      reset = 1'b0; req = 3'b111; we = 3'b000; addr = '0; wdata = '0;
      repeat (3) begin
         @(negedge clk); #1;
         chk("rst_gnt", 32'(gnt), 32'd0);
         chk("rst_mem_en", 32'(mem_en), 32'd0);
         chk("rst_rvalid", 32'(rvalid), 32'd0);
      end
      req   = 3'b000;
      reset = 1'b1;

      for (int i = 0; i < 15; i++) drive(tbl[i]);

      // Loader streams writes while fetch reads: 4 loader grants, then one fetch.
      lk = 0; fj = 0; run = 0;
      for (int c = 0; c < 40 && (lk < 10 || fj < 10); c++) begin
         v     = '0;
         v.req = {1'b0, fj < 10, lk < 10};
         v.we  = 3'b001;
         v.a0  = 8'(lk);
         v.d0  = 16'hA000 + 16'(lk);
         v.a1  = 8'(fj);
         if (v.req[0] && (!v.req[1] || run < 4)) v.gnt = 3'b001;
         else if (v.req[1])                      v.gnt = 3'b010;
         else                                    v.gnt = 3'b000;
         drive(v);
         if (v.gnt[0]) begin lk++; run = v.req[1] ? run + 1 : 0; end
         if (v.gnt[1]) begin fj++; run = 0; end
      end
      drive(mk(3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 16'h0, 16'h0, 3'b000));
      for (int k = 0; k < 10; k++) chk("ram_load", 32'(ram[k]), 32'(16'hA000 + 16'(k)));

      // Reset asserted before the edge that would complete a granted fetch read.
      @(negedge clk);
      check_rv();
      req = 3'b010; we = 3'b000; addr = '0;
      #1 chk("pre_rst_gnt", 32'(gnt), 32'b010);
      #1 reset = 1'b0;
      #1 chk("in_rst_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
      req = 3'b000;
      chk("rst_discard", 32'(rvalid), 32'd0);
      reset = 1'b1;
      drive(mk(3'b110, 3'b000, 8'd0, 8'd0, 8'd7, 16'h0, 16'h0, 3'b010));
      drive(mk(3'b000, 3'b000, 8'd0, 8'd0, 8'd0, 16'h0, 16'h0, 3'b000));
      @(negedge clk);
      check_rv();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
